priority_grant_scheduler64: RTL

PRIORITY_GRANT_SCHEDULER64 -- requirements
Module: priority_grant_scheduler64

---
 rtl/priority_grant_scheduler64_pkg.sv | 17 +
 rtl/priority_encoder64.sv | 17 +
 rtl/priority_grant_scheduler64.sv | 92 +++++++++
 3 files changed

// File: rtl/priority_grant_scheduler64_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 64-way grant scheduler.
package priority_grant_scheduler64_pkg;

  localparam int WIDTH = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/priority_encoder64.sv
// Combinational highest-set-bit encoder; an all-zero input yields index 0.
module priority_encoder64
  import priority_grant_scheduler64_pkg::*;
(
  input  logic [63:0] vec,
  output logic [5:0]  idx
);

  // Later (higher) set bits overwrite earlier ones, so the top set bit wins.
  always_comb begin
    idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      idx = vec[i] ? 6'(i) : idx;
    end
  end

endmodule

// File: rtl/priority_grant_scheduler64.sv
// Pending-request scheduler offering the highest eligible index with a valid/ready handshake.
module priority_grant_scheduler64
  import priority_grant_scheduler64_pkg::*;
#(
  parameter int WIDTH = priority_grant_scheduler64_pkg::WIDTH,
  parameter int IDX_W = priority_grant_scheduler64_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] pending,
  output logic [CNT_W-1:0] grant_count
);

  state_t           state_r;
  state_t           state_next_s;
  logic             transfer_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] pending_next_s;
  logic [WIDTH-1:0] eligible_s;
  logic             any_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] idx_next_s;

  priority_encoder64 u_enc (
    .vec (eligible_s),
    .idx (top_idx_s)
  );

  // Pending update: a new request on the bit being cleared wins over the clear.
  always_comb begin
    transfer_s     = grant_valid & grant_ready;
    clr_s          = transfer_s ? onehot(grant_idx) : {WIDTH{1'b0}};
    pending_next_s = (pending & ~clr_s) | req_in;
    eligible_s     = pending_next_s & mask_in;
    any_s          = |eligible_s;
  end

  // Offer FSM: an offer is only replaced after it has been accepted.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = grant_idx;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_next_s = OFFER;
          idx_next_s   = top_idx_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      OFFER: begin
        if (transfer_s && any_s) begin
          idx_next_s = top_idx_s;
        end else if (transfer_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OFFER;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, outputs and saturating accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= {IDX_W{1'b0}};
      pending     <= {WIDTH{1'b0}};
      grant_count <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      grant_valid <= (state_next_s == OFFER);
      grant_idx   <= idx_next_s;
      pending     <= pending_next_s;
      if (transfer_s && (grant_count != {CNT_W{1'b1}})) begin
        grant_count <= grant_count + 16'd1;
      end else begin
        grant_count <= grant_count;
      end
    end
  end

endmodule
